joypad_responder: RTL

- Responder end of the CPU controller-port interface.
- The CPU side drives the strobe latch from writes to $4016 (addr4016w) and the active-low read strobes for $4016/$4017 (naddr4016r/naddr4017r).
- This block models two standard NES pads as parallel-load serial shift registers.
- It returns one serial data bit per pad for the CPU read mux to place on D0.

---
 rtl/joypad_pkg.sv | 31 +++
 rtl/joypad_shift.sv | 64 ++++++
 rtl/joypad_responder.sv | 110 +++++++++++
 3 files changed

// File: rtl/joypad_pkg.sv
// joypad_pkg: shared constants for the controller-port responder.
//   BTN_A..BTN_RIGHT  button bit positions in a pad word
//   PAD_BITS_DEF      default shift length (standard pad)
//   CNT_W             width of the per-pad read counter
//   turbo_kill()      whether a button bit is suppressed by turbo this frame
package joypad_pkg;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam int PAD_BITS_DEF = 8;
  localparam int CNT_W        = 4;

  // A turbo-enabled button only reaches the shift register while phase is 1.
  function automatic logic turbo_kill(input int unsigned idx,
                                      input logic [1:0]  en,
                                      input logic        phase);
    logic kill;
    kill = 1'b0;
    if (idx == BTN_A) kill = en[0] & ~phase;
    if (idx == BTN_B) kill = en[1] & ~phase;
    return kill;
  endfunction

endpackage

// File: rtl/joypad_shift.sv
// joypad_shift: one pad's parallel-load serial shift register.
//   clk_i, rst_i  clock and async active-high reset
//   strobe_i      1 = continuously load load_i, 0 = hold/shift
//   nread_i       active-low read strobe; advance on its rising edge
//   load_i        button word to load
//   data_o        registered serial bit (always shift[0])
//   count_o       reads since last load, saturating at PAD_BITS
module joypad_shift
  import joypad_pkg::*;
#(
  parameter int PAD_BITS = PAD_BITS_DEF,
  parameter bit FILL_BIT = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                strobe_i,
  input  logic                nread_i,
  input  logic [PAD_BITS-1:0] load_i,
  output logic                data_o,
  output logic [CNT_W-1:0]    count_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PAD_BITS);

  logic [PAD_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                prev_q;
  logic                data_q;
  logic                advance;

  // Bit is consumed when the read strobe is released, not when it falls.
  assign advance = ~strobe_i & ~prev_q & nread_i;

  always_comb begin
    shift_d = shift_q;
    count_d = count_q;
    if (strobe_i) begin
      shift_d = load_i;
      count_d = '0;
    end else if (advance) begin
      shift_d                = shift_q >> 1;
      shift_d[PAD_BITS-1]    = FILL_BIT;
      if (count_q != CNT_MAX) count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_q <= '0;
      count_q <= '0;
      prev_q  <= 1'b1;
      data_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      count_q <= count_d;
      prev_q  <= nread_i;
      data_q  <= shift_d[0];
    end
  end

  assign data_o  = data_q;
  assign count_o = count_q;

endmodule

// File: rtl/joypad_responder.sv
// joypad_responder: responder side of the CPU controller port, two pads.
//   clock, reset            system clock, async active-high reset
//   addr4016w[2:0]          $4016 latch; bit0 = strobe, bits 2:1 unused
//   naddr4016r/naddr4017r   active-low read strobes for pad 1 / pad 2
//   buttons1/buttons2       active-high button words
//   turbo1/turbo2           turbo enables (bit0 A, bit1 B)
//   pad1_data/pad2_data     registered serial bits for D0
//   pad1_count/pad2_count   reads since last load (saturating)
// Optional: define JOYPAD_TURBO_EN to gate A/B with a shared turbo phase that
// toggles every TURBO_DIV strobe falling edges. Without it turbo inputs are
// ignored and no divider/phase state exists.
module joypad_responder
  import joypad_pkg::*;
#(
  parameter int PAD_BITS  = PAD_BITS_DEF,
  parameter bit FILL_BIT  = 1'b1,
  parameter int TURBO_DIV = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [2:0]          addr4016w,
  input  logic                naddr4016r,
  input  logic                naddr4017r,
  input  logic [PAD_BITS-1:0] buttons1,
  input  logic [PAD_BITS-1:0] buttons2,
  input  logic [1:0]          turbo1,
  input  logic [1:0]          turbo2,
  output logic                pad1_data,
  output logic                pad2_data,
  output logic [CNT_W-1:0]    pad1_count,
  output logic [CNT_W-1:0]    pad2_count
);

  logic                strobe;
  logic [PAD_BITS-1:0] load1, load2;

  assign strobe = addr4016w[0];

`ifdef JOYPAD_TURBO_EN
  localparam int DIV_W = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TURBO_DIV - 1);

  logic             strobe_q;
  logic [DIV_W-1:0] div_q;
  logic             phase_q;
  logic             unused_ok;

  assign unused_ok = ^addr4016w[2:1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      strobe_q <= 1'b0;
      div_q    <= '0;
      phase_q  <= 1'b0;
    end else begin
      strobe_q <= strobe;
      if (strobe_q & ~strobe) begin
        if (div_q == DIV_LAST) begin
          div_q   <= '0;
          phase_q <= ~phase_q;
        end else begin
          div_q <= div_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    load1 = buttons1;
    load2 = buttons2;
    for (int unsigned i = 0; i < PAD_BITS; i++) begin
      if (turbo_kill(i, turbo1, phase_q)) load1[i] = 1'b0;
      if (turbo_kill(i, turbo2, phase_q)) load2[i] = 1'b0;
    end
  end
`else
  logic unused_ok;

  assign unused_ok = ^{addr4016w[2:1], turbo1, turbo2};
  assign load1     = buttons1;
  assign load2     = buttons2;
`endif

  joypad_shift #(
    .PAD_BITS (PAD_BITS),
    .FILL_BIT (FILL_BIT)
  ) u_pad1 (
    .clk_i    (clock),
    .rst_i    (reset),
    .strobe_i (strobe),
    .nread_i  (naddr4016r),
    .load_i   (load1),
    .data_o   (pad1_data),
    .count_o  (pad1_count)
  );

  joypad_shift #(
    .PAD_BITS (PAD_BITS),
    .FILL_BIT (FILL_BIT)
  ) u_pad2 (
    .clk_i    (clock),
    .rst_i    (reset),
    .strobe_i (strobe),
    .nread_i  (naddr4017r),
    .load_i   (load2),
    .data_o   (pad2_data),
    .count_o  (pad2_count)
  );

endmodule
